// File: rtl/tick_timer_if.sv
// Control and status bundle for tick_timer.
// The irq_clr/irq pair exists only when TICK_TIMER_IRQ_EN is defined.
interface tick_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             mode;
  logic             start;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] divisor;
  logic             div_valid;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
`ifdef TICK_TIMER_IRQ_EN
  logic             irq_clr;
  logic             irq;
`endif

  modport master (
    output enable,
    output mode,
    output start,
    output load,
    output load_value,
    output divisor,
    output div_valid,
`ifdef TICK_TIMER_IRQ_EN
    output irq_clr,
    input  irq,
`endif
    input  count,
    input  tick,
    input  busy
  );

  modport slave (
    input  enable,
    input  mode,
    input  start,
    input  load,
    input  load_value,
    input  divisor,
    input  div_valid,
`ifdef TICK_TIMER_IRQ_EN
    input  irq_clr,
    output irq,
`endif
    output count,
    output tick,
    output busy
  );
endinterface

// File: rtl/tick_timer.sv
// Programmable-period tick timer with free-running and one-shot modes.
// Optional sticky interrupt output enabled by defining TICK_TIMER_IRQ_EN.
module tick_timer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RESET_DIVISOR = 256
) (
  input  logic        clock,
  input  logic        reset,
  tick_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] term;
  logic             tick_q;
  logic             tick_d;
  logic             busy_q;
  logic             busy_d;

  // Divisor 0 underflows to all ones, giving the full 2^WIDTH period.
  assign term = div_q - WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      div_q   <= WIDTH'(RESET_DIVISOR);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
    end
  end

  // Control priority: load, then start, then count advance.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    div_d   = bus.div_valid ? bus.divisor : div_q;
    if (bus.load) begin
      count_d = bus.load_value;
    end else if (bus.start) begin
      count_d = '0;
      state_d = RUN;
    end else if ((state_q == RUN) && bus.enable) begin
      // >= so a count pushed past the terminal still wraps.
      if (count_q >= term) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (bus.mode) begin
          state_d = DONE;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
    busy_d = (state_d == RUN);
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.busy  = busy_q;

`ifdef TICK_TIMER_IRQ_EN
  logic irq_q;

  // Sticky on a rising tick; the set beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (tick_d && !tick_q) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus random traffic
// compared against a cycle-level reference model of the timer rules.
module tb_tick_timer;
  localparam int unsigned W  = 8;
  localparam int unsigned RD = 256;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic clock = 1'b0;
  logic reset;

  tick_timer_if #(.WIDTH(W)) bus ();

  tick_timer #(.WIDTH(W), .RESET_DIVISOR(RD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_phase = P_IDLE;
  int m_count = 0;
  int m_div   = RD % (1 << W);
  bit m_tick  = 1'b0;
  bit m_irq   = 1'b0;

  // Apply one clock's worth of inputs to DUT and model, then wait past the edge.
  task automatic cycle(input bit rst, input bit en, input bit md, input bit st,
                       input bit ld, input int lv, input int dv, input bit dvld,
                       input bit clr);
    int period;
    bit prev_tick;
    reset          = rst;
    bus.enable     = en;
    bus.mode       = md;
    bus.start      = st;
    bus.load       = ld;
    bus.load_value = W'(lv);
    bus.divisor    = W'(dv);
    bus.div_valid  = dvld;
`ifdef TICK_TIMER_IRQ_EN
    bus.irq_clr    = clr;
`endif
    period    = (m_div == 0) ? (1 << W) : m_div;
    prev_tick = m_tick;
    m_tick    = 1'b0;
    if (rst) begin
      m_phase = P_IDLE;
      m_count = 0;
      m_div   = RD % (1 << W);
      m_irq   = 1'b0;
    end else begin
      if (ld) begin
        m_count = lv % (1 << W);
      end else if (st) begin
        m_count = 0;
        m_phase = P_RUN;
      end else if (m_phase == P_RUN && en) begin
        if (m_count >= period - 1) begin
          m_count = 0;
          m_tick  = 1'b1;
          if (md) m_phase = P_DONE;
        end else begin
          m_count = m_count + 1;
        end
      end
      if (dvld) m_div = dv % (1 << W);
      if (m_tick && !prev_tick) m_irq = 1'b1;
      else if (clr) m_irq = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 9, 3, 1, 0);
    n_tests++;
    if (bus.count !== W'(0)) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    n_tests++;
    if (bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick: got %b want 0", bus.tick);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_free_run();
    int ticks;
    int exp_c;
    ticks = 0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(0) || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL free_start: got count=%0d busy=%b want 0/1", bus.count, bus.busy);
    end
    for (int k = 1; k <= 512; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      exp_c = k % 256;
      if (bus.tick === 1'b1) ticks++;
      n_tests++;
      if (bus.count !== W'(exp_c)) begin
        n_fail++; $display("FAIL free_count k=%0d: got %0d want %0d", k, bus.count, exp_c);
      end
      n_tests++;
      if (bus.tick !== (exp_c == 0)) begin
        n_fail++; $display("FAIL free_tick k=%0d: got %b want %b", k, bus.tick, exp_c == 0);
      end
      n_tests++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL free_busy k=%0d: got %b want 1", k, bus.busy);
      end
    end
    n_tests++;
    if (ticks != 2) begin
      n_fail++; $display("FAIL free_tick_total: got %0d want 2", ticks);
    end
  endtask

  task automatic test_one_shot();
    int seq [5];
    seq = '{1, 2, 3, 4, 0};
    cycle(0, 0, 1, 0, 0, 0, 5, 1, 0);
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(0) || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_start: got count=%0d busy=%b want 0/1", bus.count, bus.busy);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus.count !== W'(seq[k]) || bus.tick !== (k == 4) || bus.busy !== (k != 4)) begin
        n_fail++;
        $display("FAIL oneshot_step k=%0d: got count=%0d tick=%b busy=%b want %0d/%b/%b",
                 k, bus.count, bus.tick, bus.busy, seq[k], k == 4, k != 4);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus.count !== W'(0) || bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_done k=%0d: got count=%0d tick=%b busy=%b want 0/0/0",
                 k, bus.count, bus.tick, bus.busy);
      end
    end
  endtask

  task automatic test_load_wrap();
    cycle(0, 0, 0, 0, 0, 0, 10, 1, 0);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(7)) begin
      n_fail++; $display("FAIL loadwrap_pre: got %0d want 7", bus.count);
    end
    cycle(0, 1, 0, 0, 1, 200, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(200) || bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL loadwrap_load: got count=%0d tick=%b want 200/0", bus.count, bus.tick);
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(0) || bus.tick !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL loadwrap_wrap: got count=%0d tick=%b busy=%b want 0/1/1",
               bus.count, bus.tick, bus.busy);
    end
  endtask

  task automatic test_load_start();
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 3, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(3) || bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL loadstart_run: got count=%0d tick=%b busy=%b want 3/0/1",
               bus.count, bus.tick, bus.busy);
    end
    // Park in DONE, then repeat the collision there.
    cycle(0, 1, 1, 0, 1, 9, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.tick !== 1'b1) begin
      n_fail++; $display("FAIL loadstart_todone: got busy=%b tick=%b want 0/1", bus.busy, bus.tick);
    end
    cycle(0, 1, 1, 1, 1, 3, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(3) || bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loadstart_done: got count=%0d tick=%b busy=%b want 3/0/0",
               bus.count, bus.tick, bus.busy);
    end
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(3)) begin
      n_fail++; $display("FAIL loadstart_hold: got %0d want 3", bus.count);
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 0, 0, 0, 200, 1, 0);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 100; k++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(100)) begin
      n_fail++; $display("FAIL resetmid_pre: got %0d want 100", bus.count);
    end
    cycle(1, 1, 0, 1, 1, 55, 0, 0, 0);
    n_tests++;
    if (bus.count !== W'(0) || bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL resetmid_state: got count=%0d tick=%b busy=%b want 0/0/0",
               bus.count, bus.tick, bus.busy);
    end
    // Divisor must be back to 256: first tick exactly 256 cycles after start.
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus.tick !== (k == 256) || bus.count !== W'(k % 256)) begin
        n_fail++;
        $display("FAIL resetmid_div k=%0d: got count=%0d tick=%b want %0d/%b",
                 k, bus.count, bus.tick, k % 256, k == 256);
      end
    end
  endtask

  task automatic test_period_one();
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus.tick !== 1'b1 || bus.count !== W'(0)) begin
        n_fail++;
        $display("FAIL period_one k=%0d: got count=%0d tick=%b want 0/1", k, bus.count, bus.tick);
      end
    end
  endtask

  task automatic test_random();
    bit r, e, s, l, dvl, clr;
    bit md;
    int lv, dv;
    md = 1'b0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      e   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) md = ~md;
      s   = ($urandom_range(0, 99) < 6);
      l   = ($urandom_range(0, 99) < 6);
      dvl = ($urandom_range(0, 99) < 5);
      lv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      dv  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      clr = ($urandom_range(0, 9) == 0);
      cycle(r, e, md, s, l, lv, dv, dvl, clr);
      n_tests++;
      if (bus.count !== W'(m_count) || bus.tick !== m_tick || bus.busy !== (m_phase == P_RUN)) begin
        n_fail++;
        $display("FAIL random i=%0d: got count=%0d tick=%b busy=%b want %0d/%b/%b",
                 i, bus.count, bus.tick, bus.busy, m_count, m_tick, m_phase == P_RUN);
      end
`ifdef TICK_TIMER_IRQ_EN
      n_tests++;
      if (bus.irq !== m_irq) begin
        n_fail++; $display("FAIL random_irq i=%0d: got %b want %b", i, bus.irq, m_irq);
      end
`endif
    end
  endtask

`ifdef TICK_TIMER_IRQ_EN
  task automatic test_irq();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_reset: got %b want 0", bus.irq);
    end
    cycle(0, 0, 0, 0, 0, 0, 4, 1, 0);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus.irq !== (k >= 4) || bus.tick !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL irq_set k=%0d: got irq=%b tick=%b want %b/%b",
                 k, bus.irq, bus.tick, k >= 4, k % 4 == 0);
      end
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus.irq !== 1'b0 || bus.count !== W'(3)) begin
      n_fail++; $display("FAIL irq_clear: got irq=%b count=%0d want 0/3", bus.irq, bus.count);
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus.irq !== 1'b1 || bus.tick !== 1'b1) begin
      n_fail++; $display("FAIL irq_set_wins: got irq=%b tick=%b want 1/1", bus.irq, bus.tick);
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_after_clear: got %b want 0", bus.irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_one_shot();
    test_load_wrap();
    test_load_start();
    test_reset_mid();
    test_period_one();
`ifdef TICK_TIMER_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter and divisor width in bits (2..32).
REQ-002 The block SHALL have parameter RESET_DIVISOR, default 256, the divisor the block uses while div_valid has never been asserted since reset.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  count-advance qualifier.
REQ-006 The block SHALL have port mode  input  1  0 = free-running wrap, 1 = one-shot.
REQ-007 The block SHALL have port start  input  1  single-cycle pulse that (re)starts counting from 0.
REQ-008 The block SHALL have port load  input  1  writes load_value into the counter.
REQ-009 The block SHALL have port load_value  input  WIDTH  value written on load.
REQ-010 The block SHALL have port divisor  input  WIDTH  period D; captured when div_valid=1.
REQ-011 The block SHALL have port div_valid  input  1  divisor capture strobe.
REQ-012 The block SHALL have port count  output  WIDTH  current counter value, registered.
REQ-013 The block SHALL have port tick  output  1  one-cycle terminal pulse, registered.
REQ-014 The block SHALL have port busy  output  1  high while in state RUN.

Function
REQ-015 The block SHALL use states IDLE, RUN and DONE, with busy=1 only in RUN.
REQ-016 The block SHALL compute terminal T = D_reg-1, where D_reg is the captured divisor, and SHALL treat D_reg=0 as period 2^WIDTH (T = all ones).
REQ-017 The block SHALL apply controls with priority reset > load > start > count advance.
REQ-018 On load, the block SHALL set count to load_value, leave the state unchanged, and emit no tick.
REQ-019 On start (no load), the block SHALL set count to 0 and enter RUN from any state; start while in RUN SHALL restart the count.
REQ-020 In RUN with enable=1, if count >= T the block SHALL set count to 0 and tick=1 on the next cycle; otherwise it SHALL set count to count+1 (mod 2^WIDTH).
REQ-021 After a wrap in RUN, the block SHALL stay in RUN when mode=0 and SHALL go to DONE when mode=1.
REQ-022 In RUN with enable=0, and in IDLE or DONE, the block SHALL hold count and keep tick=0.
REQ-023 Because wrap uses >=, a load or divisor change that leaves count above T SHALL cause a wrap on the next enabled cycle.
REQ-024 D_reg SHALL update on the clock edge where div_valid=1 and SHALL take effect from the following cycle.
REQ-025 Latency: with enable held 1, start at edge 0 and D >= 1, tick SHALL be high for exactly the cycle after edge D; D=1 SHALL give tick on every cycle.
REQ-026 tick SHALL never be high for two consecutive cycles unless D_reg=1.

Reset
REQ-027 With reset=1 at a clock edge, the block SHALL set state to IDLE, count=0, tick=0, busy=0 and D_reg=RESET_DIVISOR truncated to WIDTH bits.
REQ-028 Reset SHALL override all other inputs, including mid-count and in the same cycle as start or load.

Configuration
REQ-029 With macro TICK_TIMER_IRQ_EN defined, the block SHALL add input irq_clr (1 bit) and output irq (1 bit).
REQ-030 When TICK_TIMER_IRQ_EN is defined, irq SHALL set on the edge where tick rises and stay set until irq_clr=1 or reset, with set winning over a simultaneous irq_clr; irq SHALL reset to 0.
REQ-031 Without TICK_TIMER_IRQ_EN, the block SHALL have neither port nor its logic, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, reset, start, enable=1, mode=0 -> count runs 0..255, tick every 256 cycles, busy=1 throughout.
REQ-033 The bench SHALL cover: divisor=5 with div_valid, start, mode=1 -> count 0,1,2,3,4,0; one tick; then DONE, busy=0, count holds 0.
REQ-034 The bench SHALL cover: D=10 with count=7, then load 200 -> next enabled cycle count=0 with tick=1.
REQ-035 The bench SHALL cover: load=1 and start=1 in the same cycle with load_value=3 -> count=3, state unchanged, no tick.
REQ-036 The bench SHALL cover: reset asserted at count=100 together with start -> IDLE, count=0, tick=0, D_reg=RESET_DIVISOR.
REQ-037 The bench SHALL cover, with TICK_TIMER_IRQ_EN and D=4: irq sets on the first tick and holds; irq_clr on a tick cycle leaves irq=1.
